// File: rtl/frame_mem_arbiter_if.sv
// Bus bundle for frame_mem_arbiter: CPU load/store port, pixel stream and frame-RAM port.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface frame_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_err;

    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] pix_data;
    logic              pix_last;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
        output pix_valid, pix_data, pix_last,
        input  pix_ready,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
        input  pix_valid, pix_data, pix_last,
        output pix_ready,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/frame_mem_arbiter.sv
// Shares the single-port frame RAM between the CPU and the display scanner (4-entry pixel FIFO).
// Define FRAME_MEM_PROTECT_EN to drop CPU writes into the frame window while scanning (cpu_err).
module frame_mem_arbiter #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned BASE   = 160000,
    parameter int unsigned LEN    = 40000
) (
    input logic                clk,
    input logic                rst,
    input logic                scan_en,
    frame_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StStop} scan_state_e;

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(BASE + LEN - 1);

    scan_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              last_cpu_q;

    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // Read-return pipeline: stage 1 is the RAM access cycle, stage 2 the data cycle.
    logic              s1_valid_q, s1_cpu_q, s1_last_q;
    logic              s2_valid_q, s2_cpu_q, s2_last_q;

    logic [DATA_W-1:0] fifo_data_q [4];
    logic [3:0]        fifo_last_q;
    logic [1:0]        wr_ptr_q, rd_ptr_q;
    logic [2:0]        fifo_count_q;

    logic [1:0]        inflight;
    logic [2:0]        occupancy;
    logic              scan_req;
    logic              cpu_win, scan_win;
    logic              prot_hit;
    logic              fifo_push, fifo_pop;
    logic              pix_valid;

    assign inflight  = {1'b0, s1_valid_q & ~s1_cpu_q} + {1'b0, s2_valid_q & ~s2_cpu_q};
    assign occupancy = fifo_count_q + {1'b0, inflight};
    assign scan_req  = scan_en && (state_q != StStop) && (occupancy < 3'd4);

`ifdef FRAME_MEM_PROTECT_EN
    logic cpu_err_q;

    assign prot_hit = bus.cpu_we && (bus.cpu_addr >= BaseAddr) && (bus.cpu_addr <= LastAddr) &&
                      (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_err_q <= 1'b0;
        end else begin
            cpu_err_q <= cpu_win && prot_hit;
        end
    end

    assign bus.cpu_err = cpu_err_q;
`else
    assign prot_hit    = 1'b0;
    assign bus.cpu_err = 1'b0;
`endif

    // On a conflict the requester that did not win last time gets the RAM.
    always_comb begin
        cpu_win  = 1'b0;
        scan_win = 1'b0;
        if (!rst) begin
            if (bus.cpu_req && scan_req) begin
                cpu_win  = ~last_cpu_q;
                scan_win = last_cpu_q;
            end else begin
                cpu_win  = bus.cpu_req;
                scan_win = scan_req;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (scan_win) begin
            ptr_d = (ptr_q == LastAddr) ? BaseAddr : ptr_q + ADDR_W'(1);
        end
        unique case (state_q)
            StIdle: if (scan_en) state_d = StRun;
            StRun: begin
                if (!scan_en) state_d = (inflight == 2'd0) ? StIdle : StStop;
            end
            StStop: if (inflight == 2'd0) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Every return to idle restarts the frame walk at the window base.
        if (state_d == StIdle) ptr_d = BaseAddr;
    end

    assign fifo_push = s2_valid_q && !s2_cpu_q;
    assign fifo_pop  = pix_valid && bus.pix_ready;
    assign pix_valid = (fifo_count_q != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ptr_q        <= BaseAddr;
            last_cpu_q   <= 1'b0;
            mem_addr_q   <= BaseAddr;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            s1_valid_q   <= 1'b0;
            s1_cpu_q     <= 1'b0;
            s1_last_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_cpu_q     <= 1'b0;
            s2_last_q    <= 1'b0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            fifo_count_q <= 3'd0;
            fifo_last_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;

            if (cpu_win) begin
                last_cpu_q <= 1'b1;
            end else if (scan_win) begin
                last_cpu_q <= 1'b0;
            end

            mem_we_q <= cpu_win && bus.cpu_we && !prot_hit;
            if (cpu_win) begin
                mem_addr_q  <= bus.cpu_addr;
                mem_wdata_q <= bus.cpu_wdata;
            end else if (scan_win) begin
                mem_addr_q <= ptr_q;
            end

            s1_valid_q <= (cpu_win && !bus.cpu_we) || scan_win;
            s1_cpu_q   <= cpu_win;
            s1_last_q  <= scan_win && (ptr_q == LastAddr);
            s2_valid_q <= s1_valid_q;
            s2_cpu_q   <= s1_cpu_q;
            s2_last_q  <= s1_last_q;

            if (fifo_push) begin
                fifo_last_q[wr_ptr_q] <= s2_last_q;
                wr_ptr_q              <= wr_ptr_q + 2'd1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            unique case ({fifo_push, fifo_pop})
                2'b10:   fifo_count_q <= fifo_count_q + 3'd1;
                2'b01:   fifo_count_q <= fifo_count_q - 3'd1;
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    // Pixel storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_data_q[wr_ptr_q] <= bus.mem_rdata;
        end
    end

    assign bus.cpu_gnt    = cpu_win;
    assign bus.cpu_rvalid = s2_valid_q && s2_cpu_q;
    assign bus.cpu_rdata  = (s2_valid_q && s2_cpu_q) ? bus.mem_rdata : '0;

    assign bus.pix_valid  = pix_valid;
    assign bus.pix_data   = pix_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign bus.pix_last   = pix_valid && fifo_last_q[rd_ptr_q];

    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter with a 4-word frame window at 160000.
// Build with FRAME_MEM_PROTECT_EN to exercise the protected-write behaviour.
module tb_frame_mem_arbiter;

    localparam int unsigned AW   = 18;
    localparam int unsigned DW   = 8;
    localparam int unsigned BASE = 160000;
    localparam int unsigned LEN  = 4;
`ifdef FRAME_MEM_PROTECT_EN
    localparam bit Prot = 1'b1;
`else
    localparam bit Prot = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic scan_en;

    frame_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    frame_mem_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .BASE  (BASE),
        .LEN   (LEN)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .scan_en(scan_en),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_pix  = 0;
    int pop_cnt  = 0;
    int ovf_cnt  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // RAM model: unwritten words read back as pat(addr); writes are kept in a small log.
    int        wr_n = 0;
    logic [AW-1:0] wr_addr [16];
    logic [DW-1:0] wr_data [16];

    function automatic logic [7:0] ram_rd(input logic [AW-1:0] a);
        logic [7:0] d;
        d = pat(int'(a));
        for (int i = 0; i < 16; i++) begin
            if (i < wr_n && wr_addr[i] == a) d = wr_data[i];
        end
        return d;
    endfunction

    always @(posedge clk) begin
        bus.mem_rdata <= ram_rd(bus.mem_addr);
        if (bus.mem_we && wr_n < 16) begin
            wr_addr[wr_n] <= bus.mem_addr;
            wr_data[wr_n] <= bus.mem_wdata;
            wr_n          <= wr_n + 1;
        end
    end

    // Pixel stream checker: every accepted pixel follows the frame walk from exp_pix.
    always @(negedge clk) begin
        if (!rst && bus.pix_valid && bus.pix_ready) begin
            check_eq("pix_data", 32'(bus.pix_data), 32'(pat(int'(BASE) + (exp_pix % LEN))));
            check_eq("pix_last", 32'(bus.pix_last), 32'((exp_pix % LEN) == LEN - 1));
            exp_pix++;
            pop_cnt++;
        end
        if (!rst && dut.fifo_push && dut.fifo_count_q == 3'd4) ovf_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        scan_en       = 1'b0;
        bus.pix_ready = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        step();
        step();
        rst     = 1'b0;
        exp_pix = 0;
    endtask

    task automatic cpu_drive(input logic we, input int addr, input logic [7:0] wd);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = AW'(addr);
        bus.cpu_wdata = wd;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_gnt"},    32'(bus.cpu_gnt), 0);
        check_eq({tag, "_rvalid"}, 32'(bus.cpu_rvalid), 0);
        check_eq({tag, "_rdata"},  32'(bus.cpu_rdata), 0);
        check_eq({tag, "_err"},    32'(bus.cpu_err), 0);
        check_eq({tag, "_pvalid"}, 32'(bus.pix_valid), 0);
        check_eq({tag, "_pdata"},  32'(bus.pix_data), 0);
        check_eq({tag, "_plast"},  32'(bus.pix_last), 0);
        check_eq({tag, "_maddr"},  32'(bus.mem_addr), BASE);
        check_eq({tag, "_mwe"},    32'(bus.mem_we), 0);
        check_eq({tag, "_mwdata"}, 32'(bus.mem_wdata), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base_pops;
        int scan_reads;
        logic [14:0] exp_gnt;

        // Reset, with a CPU request held that must be ignored.
        rst = 1'b1;
        scan_en = 1'b0;
        bus.pix_ready = 1'b0;
        cpu_drive(1'b0, 5, 8'h00);
        step();
        step();
        #1;
        check_reset_outputs("reset");
        bus.cpu_req = 1'b0;
        rst = 1'b0;

        // CPU read of 5, write of 7, read-back of 7 with the scanner idle.
        step(); cpu_drive(1'b0, 5, 8'h00); #1;
        check_eq("rd5_gnt", 32'(bus.cpu_gnt), 1);
        step(); bus.cpu_req = 1'b0; #1;
        check_eq("rd5_maddr", 32'(bus.mem_addr), 5);
        check_eq("rd5_mwe", 32'(bus.mem_we), 0);
        check_eq("rd5_rvalid_t1", 32'(bus.cpu_rvalid), 0);
        step(); #1;
        check_eq("rd5_rvalid_t2", 32'(bus.cpu_rvalid), 1);
        check_eq("rd5_rdata", 32'(bus.cpu_rdata), 32'(pat(5)));
        step(); #1;
        check_eq("rd5_rvalid_t3", 32'(bus.cpu_rvalid), 0);
        step(); cpu_drive(1'b1, 7, 8'hA5); #1;
        check_eq("wr7_gnt", 32'(bus.cpu_gnt), 1);
        step(); bus.cpu_req = 1'b0; #1;
        check_eq("wr7_mwe", 32'(bus.mem_we), 1);
        check_eq("wr7_maddr", 32'(bus.mem_addr), 7);
        check_eq("wr7_mwdata", 32'(bus.mem_wdata), 32'h A5);
        check_eq("wr7_err", 32'(bus.cpu_err), 0);
        step(); #1;
        check_eq("wr7_mwe_off", 32'(bus.mem_we), 0);
        check_eq("wr7_no_rvalid", 32'(bus.cpu_rvalid), 0);
        step(); cpu_drive(1'b0, 7, 8'h00); #1;
        check_eq("rd7_gnt", 32'(bus.cpu_gnt), 1);
        step(); bus.cpu_req = 1'b0;
        step(); #1;
        check_eq("rd7_rvalid", 32'(bus.cpu_rvalid), 1);
        check_eq("rd7_rdata", 32'(bus.cpu_rdata), 32'h A5);

        // Scanner alone at full rate: address walk, wrap and first-pixel latency.
        step();
        exp_pix = 0;
        scan_en = 1'b1;
        bus.pix_ready = 1'b1;
        #1;
        check_eq("scan_pv_t0", 32'(bus.pix_valid), 0);
        for (int i = 1; i <= 12; i++) begin
            step(); #1;
            check_eq("scan_maddr", 32'(bus.mem_addr), BASE + ((i - 1) % LEN));
            check_eq("scan_pvalid", 32'(bus.pix_valid), 32'(i >= 3));
        end

        // Drop scan_en with two reads in flight; both must still land in the FIFO.
        step();
        scan_en = 1'b0;
        bus.pix_ready = 1'b0;
        base_pops = pop_cnt;
        repeat (4) begin
            step(); #1;
            check_eq("stop_maddr", 32'(bus.mem_addr), BASE);
            check_eq("stop_pvalid", 32'(bus.pix_valid), 1);
        end
        bus.pix_ready = 1'b1;
        repeat (6) step();
        #1;
        check_eq("stop_drained", 32'(pop_cnt - base_pops), 3);
        check_eq("stop_empty", 32'(bus.pix_valid), 0);

        // Re-enable: the walk restarts at the window base.
        exp_pix = 0;
        scan_en = 1'b1;
        step(); #1;
        check_eq("restart_addr0", 32'(bus.mem_addr), BASE);
        step(); #1;
        check_eq("restart_addr1", 32'(bus.mem_addr), BASE + 1);

        // CPU held on continuously against a free-running scanner: strict alternation.
        do_reset();
        step();
        scan_en = 1'b1;
        bus.pix_ready = 1'b1;
        cpu_drive(1'b0, 5, 8'h00);
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("alt_gnt", 32'(bus.cpu_gnt), 32'(i % 2 == 0));
            if (i > 0) begin
                check_eq("alt_maddr", 32'(bus.mem_addr),
                         ((i - 1) % 2 == 0) ? 5 : BASE + (((i - 2) / 2) % LEN));
            end
            check_eq("alt_rvalid", 32'(bus.cpu_rvalid), 32'(i >= 2 && i % 2 == 0));
            if (i >= 2 && i % 2 == 0) check_eq("alt_rdata", 32'(bus.cpu_rdata), 32'(pat(5)));
            step();
        end

        // Consumer stalled: four scanner reads fill the FIFO, then the CPU gets every cycle.
        do_reset();
        step();
        scan_en = 1'b1;
        bus.pix_ready = 1'b0;
        cpu_drive(1'b0, 5, 8'h00);
        exp_gnt = 15'b111_1111_0101_0101;
        scan_reads = 0;
        for (int i = 0; i < 15; i++) begin
            #1;
            check_eq("bp_gnt", 32'(bus.cpu_gnt), 32'(exp_gnt[i]));
            if (!bus.cpu_gnt) scan_reads++;
            step();
        end
        check_eq("bp_scan_reads", 32'(scan_reads), 4);
        bus.pix_ready = 1'b1;
        #1;
        check_eq("bp_release_gnt", 32'(bus.cpu_gnt), 1);
        step();
        bus.pix_ready = 1'b0;
        #1;
        check_eq("bp_one_scan", 32'(bus.cpu_gnt), 0);
        for (int i = 0; i < 6; i++) begin
            step(); #1;
            if (i == 0) check_eq("bp_wrap_addr", 32'(bus.mem_addr), BASE);
            check_eq("bp_cpu_only", 32'(bus.cpu_gnt), 1);
        end
        check_eq("bp_pops", 32'(exp_pix), 1);

        // Reset in the middle of a frame with a CPU read outstanding.
        do_reset();
        step();
        scan_en = 1'b1;
        bus.pix_ready = 1'b1;
        cpu_drive(1'b1, 9, 8'h3C);
        #1;
        check_eq("mid_wr_gnt", 32'(bus.cpu_gnt), 1);
        step(); cpu_drive(1'b0, 5, 8'h00); #1;
        check_eq("mid_scan_turn", 32'(bus.cpu_gnt), 0);
        step(); #1;
        check_eq("mid_rd_gnt", 32'(bus.cpu_gnt), 1);
        step();
        rst = 1'b1;
        #1;
        check_eq("mid_gnt_in_rst", 32'(bus.cpu_gnt), 0);
        step();
        rst = 1'b0;
        bus.cpu_req = 1'b0;
        scan_en = 1'b0;
        exp_pix = 0;
        #1;
        check_reset_outputs("mid_rst");
        step(); #1;
        check_eq("mid_no_rvalid", 32'(bus.cpu_rvalid), 0);
        check_eq("mid_no_pixel", 32'(bus.pix_valid), 0);

        // Writes into and outside the frame window while the scanner is running.
        do_reset();
        step();
        scan_en = 1'b1;
        bus.pix_ready = 1'b0;
        repeat (8) step();
        cpu_drive(1'b1, BASE + 2, 8'h77);
        #1;
        check_eq("pw_gnt", 32'(bus.cpu_gnt), 1);
        step(); bus.cpu_req = 1'b0; #1;
        check_eq("pw_maddr", 32'(bus.mem_addr), BASE + 2);
        check_eq("pw_mwe", 32'(bus.mem_we), 32'(!Prot));
        check_eq("pw_err", 32'(bus.cpu_err), 32'(Prot));
        step(); #1;
        check_eq("pw_err_pulse", 32'(bus.cpu_err), 0);
        cpu_drive(1'b1, 100, 8'h42);
        #1;
        check_eq("uw_gnt", 32'(bus.cpu_gnt), 1);
        step(); bus.cpu_req = 1'b0; #1;
        check_eq("uw_mwe", 32'(bus.mem_we), 1);
        check_eq("uw_err", 32'(bus.cpu_err), 0);
        step(); cpu_drive(1'b0, 100, 8'h00);
        step(); cpu_drive(1'b0, BASE + 2, 8'h00);
        step(); bus.cpu_req = 1'b0; #1;
        check_eq("uw_rvalid", 32'(bus.cpu_rvalid), 1);
        check_eq("uw_rdata", 32'(bus.cpu_rdata), 32'h42);
        step(); #1;
        check_eq("pw_rvalid", 32'(bus.cpu_rvalid), 1);
        check_eq("pw_rdata", 32'(bus.cpu_rdata), Prot ? 32'(pat(int'(BASE) + 2)) : 32'h77);

        check_eq("no_fifo_overflow", 32'(ovf_cnt), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
